launchpad_pad_arbiter: RTL and testbench

Registered, parametrised N-channel priority encoder for the LaunchPad key matrix; successor to the 3-input combinational priority encoder. It captures rising edges on N pad lines into a pending register. It selects one pending channel by fixed (highest index wins) or round-robin priority and presents it as one-hot plus binary index under a VALID/ACK handshake. It sits between the pad debouncers and the sound/LED sequencer.

---
 rtl/launchpad_pad_arbiter.sv | 123 ++++++++++++
 tb/tb_launchpad_pad_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/launchpad_pad_arbiter.sv
// launchpad_pad_arbiter
// Registered N-channel pad arbiter for the LaunchPad key matrix. Rising edges
// on the debounced pad lines are latched into a pending register. One pending
// channel is granted at a time, chosen by fixed priority (highest index wins)
// or by round-robin starting below the last acknowledged channel.
//
// Handshake: VALID high means DOUT/IDX carry a grant. All three stay frozen
// until the consumer samples ACK high on a rising CLK edge while VALID is
// high. That edge retires the grant and clears its pending bit. ACK while
// VALID is low has no effect. A new grant can appear one edge later at the
// earliest.
module launchpad_pad_arbiter #(
  parameter int N = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N-1:0]         D,
  input  logic                 MODE,
  input  logic                 CLR,
  input  logic                 ACK,
  output logic                 VALID,
  output logic [N-1:0]         DOUT,
  output logic [$clog2(N)-1:0] IDX,
  output logic [N-1:0]         PEND,
  output logic                 OVF,
  output logic                 state_dbg
);

  localparam int IDXW = $clog2(N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state;
  logic [N-1:0]    d_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr_mask;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] sel_idx;

  assign state_dbg = state;

  // Edge detect, and the bit retired by a grant that is accepted this cycle.
  always_comb begin
    rise     = D & ~d_q;
    clr_mask = (VALID && ACK) ? (N'(1) << IDX) : '0;
  end

  // Pick a channel from the registered pending set, not this cycle's rises.
  always_comb begin
    int  j;
    logic found;
    sel_idx = '0;
    found   = 1'b0;
    j       = 0;
    if (!MODE) begin
      for (int i = 0; i < N; i++) begin
        if (PEND[i]) sel_idx = IDXW'(i);
      end
    end else begin
      // Descending from last-1, wrapping, with last itself checked at the end.
      for (int k = 1; k <= N; k++) begin
        j = (int'(last) - k + N) % N;
        if (!found && PEND[j]) begin
          sel_idx = IDXW'(j);
          found   = 1'b1;
        end
      end
    end
  end

  // Pending/overflow bookkeeping and the two-state grant machine.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      d_q   <= '0;
      PEND  <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
      DOUT  <= '0;
      IDX   <= '0;
      last  <= '0;
      state <= S_IDLE;
    end else begin
      d_q <= D;
      if (CLR) begin
        PEND  <= '0;
        OVF   <= 1'b0;
        VALID <= 1'b0;
        DOUT  <= '0;
        IDX   <= '0;
        last  <= '0;
        state <= S_IDLE;
      end else begin
        // A fresh press on a bit being retired keeps that bit pending.
        PEND <= (PEND & ~clr_mask) | rise;
        if (|(rise & PEND & ~clr_mask)) OVF <= 1'b1;
        case (state)
          S_IDLE: begin
            if (|PEND) begin
              DOUT  <= N'(1) << sel_idx;
              IDX   <= sel_idx;
              VALID <= 1'b1;
              state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (ACK) begin
              VALID <= 1'b0;
              DOUT  <= '0;
              IDX   <= '0;
              last  <= IDX;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_launchpad_pad_arbiter.sv
// Directed bench for launchpad_pad_arbiter (N=16): reset, fixed priority,
// round-robin, handshake hold, overflow/collision and clear.
module tb_launchpad_pad_arbiter;

  localparam int N    = 16;
  localparam int IDXW = 4;

  // ---------------- clock / reset ----------------
  logic            CLK;
  logic            RST_N;
  logic [N-1:0]    D;
  logic            MODE;
  logic            CLR;
  logic            ACK;
  logic            VALID;
  logic [N-1:0]    DOUT;
  logic [IDXW-1:0] IDX;
  logic [N-1:0]    PEND;
  logic            OVF;
  logic            state_dbg;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  launchpad_pad_arbiter #(.N(N)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .D         (D),
    .MODE      (MODE),
    .CLR       (CLR),
    .ACK       (ACK),
    .VALID     (VALID),
    .DOUT      (DOUT),
    .IDX       (IDX),
    .PEND      (PEND),
    .OVF       (OVF),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [IDXW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Wait for a grant, compare it against the queue head, then accept it.
  task automatic serve(input string tag, output int waited, output logic [IDXW-1:0] got);
    logic [IDXW-1:0] e;
    waited = 0;
    while (!VALID && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, 32'(VALID), 32'd1);
    got = IDX;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, 32'(IDX), 32'(e));
      check({tag, "_dout"}, 32'(DOUT), 32'(16'h0001 << e));
      check({tag, "_state"}, 32'(state_dbg), 32'd1);
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    check({tag, "_dropped"}, 32'(VALID), 32'd0);
    check({tag, "_dout0"}, 32'(DOUT), 32'd0);
  endtask

  // Hard stop if something wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int              w;
    logic [IDXW-1:0] g;
    RST_N = 1'b0;
    D     = 16'hFFFF;
    MODE  = 1'b0;
    CLR   = 1'b0;
    ACK   = 1'b0;

    // Reset held three cycles with all pads high.
    repeat (3) step();
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_idx", 32'(IDX), 32'd0);
    check("rst_pend", 32'(PEND), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    RST_N = 1'b1;
    step();
    check("rel_pend", 32'(PEND), 32'h0000FFFF);
    check("rel_valid", 32'(VALID), 32'd0);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    D   = '0;
    check("clr0_pend", 32'(PEND), 32'd0);
    check("clr0_valid", 32'(VALID), 32'd0);
    step();

    // Fixed priority: 3, 9, 12 together -> 12, 9, 3.
    MODE = 1'b0;
    D    = 16'h1208;
    exp_q.push_back(4'd12);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd3);
    step();
    check("fix_pend", 32'(PEND), 32'h00001208);
    check("fix_lat1", 32'(VALID), 32'd0);
    D = '0;
    step();
    check("fix_lat2", 32'(VALID), 32'd1);
    serve("fix_a", w, g);
    check("fix_a_wait", 32'(w), 32'd0);
    serve("fix_b", w, g);
    check("fix_b_gap", 32'(w), 32'd1);
    serve("fix_c", w, g);
    check("fix_c_gap", 32'(w), 32'd1);
    check("fix_pend0", 32'(PEND), 32'd0);

    // Round-robin from a cleared LAST, re-pressing each granted pad.
    CLR = 1'b1;
    step();
    CLR  = 1'b0;
    MODE = 1'b1;
    D    = 16'hC004;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(4'd15);
      exp_q.push_back(4'd14);
      exp_q.push_back(4'd2);
    end
    step();
    D = '0;
    step();
    for (int r = 0; r < 6; r++) begin
      serve("rr", w, g);
      D = 16'h0001 << g;
      step();
      D = '0;
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("rr_clr_pend", 32'(PEND), 32'd0);

    // Handshake hold: grant 5 stays frozen while D[10] rises and MODE toggles.
    MODE = 1'b0;
    D    = 16'h0020;
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd10);
    step();
    D = '0;
    step();
    for (int c = 0; c < 10; c++) begin
      D    = (c == 2) ? 16'h0400 : 16'h0000;
      MODE = ~MODE;
      step();
      check("hold_dout", 32'(DOUT), 32'h00000020);
      check("hold_idx", 32'(IDX), 32'd5);
    end
    D    = '0;
    MODE = 1'b0;
    serve("hold_a", w, g);
    serve("hold_b", w, g);

    // Overflow: 7 pending behind a held grant of 8, then pressed again.
    D = 16'h0100;
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd7);
    step();
    D = '0;
    step();
    check("ovf_hold8", 32'(IDX), 32'd8);
    D = 16'h0080;
    step();
    D = '0;
    step();
    check("ovf_pre", 32'(OVF), 32'd0);
    D = 16'h0080;
    step();
    D = '0;
    check("ovf_set", 32'(OVF), 32'd1);
    serve("ovf_a", w, g);
    serve("ovf_b", w, g);
    check("ovf_sticky", 32'(OVF), 32'd1);

    // Collision: D[4] rises on the same edge that ACK retires grant 4.
    D = 16'h0010;
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd4);
    step();
    D = '0;
    step();
    check("col_idx", 32'(IDX), 32'd4);
    void'(exp_q.pop_front());
    ACK = 1'b1;
    D   = 16'h0010;
    step();
    ACK = 1'b0;
    D   = '0;
    check("col_valid0", 32'(VALID), 32'd0);
    check("col_pend4", 32'(PEND), 32'h00000010);
    serve("col_regrant", w, g);

    // CLR during HOLD with ACK and a new rise on D[1].
    D = 16'h0040;
    step();
    D = '0;
    step();
    check("clr_hold_idx", 32'(IDX), 32'd6);
    CLR = 1'b1;
    ACK = 1'b1;
    D   = 16'h0002;
    step();
    CLR = 1'b0;
    ACK = 1'b0;
    check("clr_pend", 32'(PEND), 32'd0);
    check("clr_valid", 32'(VALID), 32'd0);
    check("clr_ovf", 32'(OVF), 32'd0);
    check("clr_dout", 32'(DOUT), 32'd0);
    check("clr_idx", 32'(IDX), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("clr_no_grant", 32'(VALID), 32'd0);
    end
    D = '0;
    step();

    // Reset mid-HOLD drops the grant.
    D = 16'h0800;
    step();
    D = '0;
    step();
    check("rst_hold_valid", 32'(VALID), 32'd1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("rst_hold_drop", 32'(VALID), 32'd0);
    check("rst_hold_pend", 32'(PEND), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
